wac_adc_serial_rx: RTL and testbench
====================================

Name: wac_adc_serial_rx

Overview:
- Downstream driver for the board's 12-bit serial ADC (AD7476-class: 16-clock frame, 4 leading zeros, then 12 data bits MSB first).
- Receives the conversion request and continuous-mode flag from the board communication controller (ADC_En, modeAdc).
- Runs the CS_N/SCLK frame, deserialises SDATA, and returns the 12-bit sample with a one-cycle ready pulse (datoAdc, readyAdc).

Parameters:
CLK_DIV, 2, SCLK half-period in clk cycles (SCLK = clk/(2*CLK_DIV)); legal range 1..255
QUIET_CYCLES, 3, cycles CS_N is held high after a frame before ready/next frame; legal range 1..255

Ports:
clk  input  1  system clock, 50 MHz max
rst  input  1  synchronous, active-high reset
start  input  1  conversion request (ADC_En); level sampled only in IDLE and DONE
mode_cont  input  1  continuous mode (modeAdc); sampled in DONE
adc_sdata  input  1  ADC serial data out
adc_cs_n  output  1  ADC chip select, active low
adc_sclk  output  1  ADC serial clock, idles high
data_out  output  12  last completed sample (datoAdc)
ready  output  1  one-cycle pulse, data_out valid (readyAdc)
busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high. All outputs are registered.
- Reset values: adc_cs_n=1, adc_sclk=1, data_out=0, ready=0, busy=0; state=IDLE; all counters and the shift register = 0.
- Reset mid-frame aborts the frame: adc_cs_n=1 and adc_sclk=1 on the next edge, no ready pulse.

States:
- IDLE: cs_n=1, sclk=1. If start=1, go to CS_SETUP.
- CS_SETUP: cs_n=0, sclk=1 for exactly CLK_DIV cycles, then go to SHIFT.
- SHIFT:
  - Half-period counter counts 0..CLK_DIV-1; sclk toggles when it reaches CLK_DIV-1. The first toggle is a falling edge.
  - On each cycle where sclk goes 0->1, shift adc_sdata into the LSB of a 16-bit register, sampled at that same clk edge.
  - A 5-bit edge counter ends SHIFT on the 16th rising edge, i.e. 32*CLK_DIV cycles after entry.
  - Then go to QUIET with cs_n=1 and sclk=1.
- QUIET: cs_n=1 for QUIET_CYCLES cycles, then go to DONE.
- DONE: lasts one cycle.
  - ready=1; data_out = shift[11:0], registered on DONE entry so it is valid in the same cycle as ready. shift[15:12] are ignored even if nonzero.
  - If mode_cont=1 or start=1, go to CS_SETUP; otherwise go to IDLE.

Timing:
- cs_n falls on the clk edge after start is seen high in IDLE.
- ready rises CLK_DIV + 32*CLK_DIV + QUIET_CYCLES cycles after cs_n falls (69 at defaults).
- Continuous frame period, cs_n fall to cs_n fall: CLK_DIV*33 + QUIET_CYCLES + 1 (70 at defaults).

Handshake rules:
- start is ignored in CS_SETUP, SHIFT and QUIET; it is not queued.
- data_out holds its value until the next DONE; it is not cleared on a new start.
- mode_cont dropping mid-frame lets the current frame complete with ready, then returns to IDLE.
- ready never lasts more than one cycle, and never coincides with cs_n=0.

Test Plan:
- Single conversion: ADC model returns frame 0x0A5C, start pulsed once -> cs_n low 69 cycles after its fall ready pulses; data_out=0xA5C; ready high exactly 1 cycle; 16 sclk falling edges; returns to IDLE, busy=0.
- Leading bits ignored: frame 0xFFFF -> data_out=0xFFF. Frame 0x8001 -> data_out=0x001.
- Continuous: mode_cont=1, model frames 0x0001, 0x0002, 0x0003 -> three ready pulses 70 cycles apart with data 0x001/0x002/0x003; mode_cont cleared during frame 3 -> IDLE after 3rd ready.
- start held high or re-pulsed during SHIFT -> no extra frame, no change in timing; start high in DONE with mode_cont=0 -> back-to-back frame begins next cycle.
- rst asserted during the 8th sclk period -> next cycle cs_n=1, sclk=1, busy=0, no ready; data_out keeps reset value 0; a new start afterwards yields a correct full frame.
- CLK_DIV=1, QUIET_CYCLES=1 build -> sclk = clk/2, ready 34 cycles after cs_n fall; frame 0x0ABC -> data_out=0xABC.

Source files
------------

// File: rtl/wac_adc_serial_rx.sv
// AD7476-class serial ADC reader: CS_N/SCLK framing, 16-bit frame -> 12-bit sample with one-cycle ready.
// Latency CLK_DIV*33+QUIET_CYCLES from cs_n fall to ready; no backpressure, start is ignored while a frame runs.
module wac_adc_serial_rx #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned QUIET_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode_cont,
  input  logic        adc_sdata,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [11:0] data_out,
  output logic        ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_QUIET,
    S_DONE
  } state_t;

  localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [7:0] QUIET_M1 = 8'(QUIET_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [4:0]  edge_q;
  // Only the last 12 bits survive a 16-bit frame, so the 4 leading bits fall off the top.
  logic [11:0] shift_q;
  logic        cs_n_q;
  logic        sclk_q;
  logic [11:0] data_q;
  logic        ready_q;
  logic        busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      shift_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_CS_SETUP;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        S_CS_SETUP: begin
          if (cnt_q == DIV_M1) begin
            state_q <= S_SHIFT;
            cnt_q   <= '0;
            edge_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_SHIFT: begin
          if (cnt_q == DIV_M1) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
            // Sample on the clk edge that drives sclk 0->1; the 16th such edge closes the frame.
            if (!sclk_q) begin
              shift_q <= {shift_q[10:0], adc_sdata};
              edge_q  <= edge_q + 5'd1;
              if (edge_q == 5'd15) begin
                state_q <= S_QUIET;
                cs_n_q  <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_QUIET: begin
          if (cnt_q == QUIET_M1) begin
            state_q <= S_DONE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            data_q  <= shift_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          cnt_q <= '0;
          if (mode_cont || start) begin
            state_q <= S_CS_SETUP;
            cs_n_q  <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign adc_cs_n = cs_n_q;
  assign adc_sclk = sclk_q;
  assign data_out = data_q;
  assign ready    = ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_wac_adc_serial_rx.sv
// Bench for wac_adc_serial_rx: default build (a) and CLK_DIV=1/QUIET_CYCLES=1 build (b) share one ADC model.
module tb_wac_adc_serial_rx;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic mode_cont;
  logic sel;
  logic sdata = 1'b0;

  logic        cs_a, sclk_a, rdy_a, busy_a;
  logic        cs_b, sclk_b, rdy_b, busy_b;
  logic [11:0] data_a, data_b;

  wire start_a = start & ~sel;
  wire mode_a  = mode_cont & ~sel;
  wire start_b = start & sel;
  wire mode_b  = mode_cont & sel;

  wire        m_cs   = sel ? cs_b   : cs_a;
  wire        m_sclk = sel ? sclk_b : sclk_a;
  wire        m_rdy  = sel ? rdy_b  : rdy_a;
  wire        m_busy = sel ? busy_b : busy_a;
  wire [11:0] m_data = sel ? data_b : data_a;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_lat;

  always #5 clk = ~clk;

  wac_adc_serial_rx dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode_cont(mode_a), .adc_sdata(sdata),
    .adc_cs_n(cs_a), .adc_sclk(sclk_a), .data_out(data_a), .ready(rdy_a), .busy(busy_a)
  );

  wac_adc_serial_rx #(.CLK_DIV(1), .QUIET_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode_cont(mode_b), .adc_sdata(sdata),
    .adc_cs_n(cs_b), .adc_sclk(sclk_b), .data_out(data_b), .ready(rdy_b), .busy(busy_b)
  );

  // ADC model: frame chosen at cs_n fall, one bit per sclk falling edge, MSB first
  logic [15:0] frame_q[$];
  logic [15:0] cur_frame = 16'h0;
  int falls = 0;
  int fall_base = 0;

  always @(negedge m_cs) begin
    if (frame_q.size() > 0) cur_frame = frame_q.pop_front();
    else cur_frame = 16'h0;
    fall_base = falls;
  end

  always @(negedge m_sclk) begin
    int idx;
    if (!m_cs) begin
      idx = 15 - (falls - fall_base);
      sdata <= (idx >= 0 && idx <= 15) ? cur_frame[idx] : 1'b0;
      falls <= falls + 1;
    end
  end

  typedef struct {
    logic [15:0] frame;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_ready(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_rdy && n < bound);
  endtask

  task automatic run_frame(input logic [15:0] fr, input logic [11:0] exp, input string nm);
    int n;
    frame_q.push_back(fr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_cs_fall"}, int'(m_cs), 0);
    wait_ready(200, n);
    chk({nm, "_latency"}, n, exp_lat);
    chk({nm, "_data"}, int'(m_data), int'(exp));
    chk({nm, "_cs_at_ready"}, int'(m_cs), 1);
    @(negedge clk);
    chk({nm, "_ready_width"}, int'(m_rdy), 0);
    chk({nm, "_busy_after"}, int'(m_busy), 0);
    chk({nm, "_sclk_falls"}, falls - fall_base, 16);
  endtask

  initial begin
    int n;
    int cnt;
    vecs[0] = '{16'h0A5C, 12'hA5C};
    vecs[1] = '{16'hFFFF, 12'hFFF};
    vecs[2] = '{16'h8001, 12'h001};
    vecs[3] = '{16'h0000, 12'h000};
    vecs[4] = '{16'h5A3C, 12'hA3C};

    rst = 1'b1; start = 1'b0; mode_cont = 1'b0; sel = 1'b0;
    exp_lat = 69;
    repeat (3) @(negedge clk);
    chk("rst_cs_a",   int'(cs_a), 1);
    chk("rst_sclk_a", int'(sclk_a), 1);
    chk("rst_data_a", int'(data_a), 0);
    chk("rst_rdy_a",  int'(rdy_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_cs_b",   int'(cs_b), 1);
    chk("rst_data_b", int'(data_b), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_frame(vecs[i].frame, vecs[i].exp, $sformatf("vec%0d", i));

    // continuous mode, mode_cont dropped during the third frame
    frame_q.push_back(16'h0001);
    frame_q.push_back(16'h0002);
    frame_q.push_back(16'h0003);
    mode_cont = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cont_cs_fall", int'(m_cs), 0);
    wait_ready(200, n);
    chk("cont_lat1", n, 69);
    chk("cont_data1", int'(m_data), 12'h001);
    wait_ready(200, n);
    chk("cont_period2", n, 70);
    chk("cont_data2", int'(m_data), 12'h002);
    repeat (20) @(negedge clk);
    mode_cont = 1'b0;
    wait_ready(200, n);
    chk("cont_period3", n, 50);
    chk("cont_data3", int'(m_data), 12'h003);
    @(negedge clk);
    chk("cont_busy_end", int'(m_busy), 0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!m_cs) cnt++;
    end
    chk("cont_no_extra_frame", cnt, 0);

    // start held through setup/shift, then re-pulsed mid-shift
    frame_q.push_back(16'h0123);
    start = 1'b1;
    @(negedge clk);
    chk("hold_cs_fall", int'(m_cs), 0);
    repeat (39) @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready(200, n);
    chk("hold_latency_rest", n, 19);
    chk("hold_data", int'(m_data), 12'h123);
    @(negedge clk);
    chk("hold_busy_after", int'(m_busy), 0);

    // start high in DONE with mode_cont=0 chains a frame immediately
    frame_q.push_back(16'h0456);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready(200, n);
    chk("b2b_lat1", n, 69);
    chk("b2b_data1", int'(m_data), 12'h456);
    frame_q.push_back(16'h0789);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_cs_fall", int'(m_cs), 0);
    chk("b2b_ready_width", int'(m_rdy), 0);
    wait_ready(200, n);
    chk("b2b_lat2", n, 69);
    chk("b2b_data2", int'(m_data), 12'h789);
    @(negedge clk);
    chk("b2b_busy_after", int'(m_busy), 0);

    // reset during the 8th sclk period
    frame_q.push_back(16'h0F0F);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (31) @(negedge clk);
    chk("rstmid_busy_before", int'(m_busy), 1);
    chk("rstmid_cs_before", int'(m_cs), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_cs", int'(m_cs), 1);
    chk("rstmid_sclk", int'(m_sclk), 1);
    chk("rstmid_busy", int'(m_busy), 0);
    chk("rstmid_data", int'(m_data), 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_rdy) cnt++;
    end
    chk("rstmid_no_ready", cnt, 0);
    chk("rstmid_data_kept", int'(m_data), 0);
    run_frame(16'h0ABC, 12'hABC, "post_rst");

    // fast build
    sel = 1'b1;
    exp_lat = 34;
    @(negedge clk);
    run_frame(16'h0ABC, 12'hABC, "fast_abc");
    run_frame(16'h8001, 12'h001, "fast_8001");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
